// File: rtl/tank_pkg.sv
// tank_pkg: shared FSM encoding, heading constants and sine table for tank motion
package tank_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_ROTATE,
    S_MOVE,
    S_COMMIT
  } state_t;
  localparam logic [3:0] UP = 4'd0;
  localparam logic [3:0] RIGHT = 4'd4;
  localparam logic [3:0] DOWN = 4'd8;
  localparam logic [3:0] LEFT = 4'd12;
  localparam logic signed [2:0] SIN16 [0:15] = '{
    3'sd0, 3'sd1, 3'sd1, 3'sd2, 3'sd2, 3'sd2, 3'sd1, 3'sd1,
    3'sd0, -3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd2, -3'sd1, -3'sd1
  };
endpackage

// File: rtl/tank_dir_lut.sv
// tank_dir_lut: heading to per-frame velocity (screen y grows downward, so dy is negated cosine)
module tank_dir_lut
  import tank_pkg::*;
(
  input  logic        [3:0] heading_i,
  output logic signed [2:0] dx_o,
  output logic signed [2:0] dy_o
);
  logic [3:0] quarter;
  // quarter-turn offset turns the sine table into a cosine lookup
  always_comb begin
    quarter = heading_i + 4'd4;
    dx_o = SIN16[heading_i];
    dy_o = -SIN16[quarter];
  end
endmodule

// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: per-frame heading/position update for the player tank sprite
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int ROT_DIV = 4,
  parameter int Y_MAX = 239,
  parameter int X_INIT = 120,
  parameter int Y_INIT = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch_left,
  input  logic       switch_right,
  input  logic       switch_up,
  input  logic       frame_start,
  output logic [3:0] heading,
  output logic [7:0] player_x,
  output logic [7:0] player_y,
  output logic       busy,
  output logic       update_done
);
  state_t state_q, state_d;
  logic [2:0] s1_q, s2_q, key_q;
  logic [3:0] heading_q, pend_h_q, pend_h_d, rot_cnt_q, rot_cnt_d;
  logic [7:0] x_q, y_q, x_d, y_d;
  logic [9:0] y_sum;
  logic signed [2:0] dx, dy;
  logic one_rot, rot_hit;
  tank_dir_lut u_lut (
    .heading_i(pend_h_q),
    .dx_o(dx),
    .dy_o(dy)
  );
  // next state, rotation and movement arithmetic; key bits are {left, right, up}
  always_comb begin
    state_d = state_q == S_IDLE   ? (frame_start ? S_SAMPLE : S_IDLE) :
              state_q == S_SAMPLE ? S_ROTATE :
              state_q == S_ROTATE ? S_MOVE :
              state_q == S_MOVE   ? S_COMMIT : S_IDLE;
    one_rot = key_q[2] ^ key_q[1];
    rot_hit = rot_cnt_q == 4'(ROT_DIV - 1);
    rot_cnt_d = (!one_rot || rot_hit) ? 4'd0 : rot_cnt_q + 4'd1;
    pend_h_d = (one_rot && rot_hit) ? (key_q[1] ? heading_q + 4'd1 : heading_q - 4'd1) : heading_q;
    y_sum = {2'b00, y_q} + {{7{dy[2]}}, dy};
    x_d = key_q[0] ? x_q + {{5{dx[2]}}, dx} : x_q;
    y_d = !key_q[0] ? y_q :
          y_sum[9] ? 8'(y_sum + 10'(Y_MAX + 1)) :
          y_sum > 10'(Y_MAX) ? 8'(y_sum - 10'(Y_MAX + 1)) : y_sum[7:0];
    busy = state_q != S_IDLE;
    update_done = state_q == S_COMMIT;
  end
  // synchronizers, FSM state and per-stage registers; outputs land on entry to COMMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      s1_q <= '0;
      s2_q <= '0;
      key_q <= '0;
      rot_cnt_q <= '0;
      pend_h_q <= '0;
      heading_q <= UP;
      x_q <= 8'(X_INIT);
      y_q <= 8'(Y_INIT);
    end else begin
      state_q <= state_d;
      s1_q <= {switch_left, switch_right, switch_up};
      s2_q <= s1_q;
      if (state_q == S_SAMPLE) key_q <= s2_q;
      if (state_q == S_ROTATE) begin
        rot_cnt_q <= rot_cnt_d;
        pend_h_q <= pend_h_d;
      end
      if (state_q == S_MOVE) begin
        heading_q <= pend_h_q;
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end
  assign heading = heading_q;
  assign player_x = x_q;
  assign player_y = y_q;
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: scenario and randomized checks of tank_motion_ctrl against a behavioural model
module tb_tank_motion_ctrl;
  logic clk = 0, reset = 1, switch_left = 0, switch_right = 0, switch_up = 0, frame_start = 0;
  logic [3:0] heading;
  logic [7:0] player_x, player_y;
  logic busy, update_done;
  int cmp = 0, err = 0;
  int h_m = 0, x_m = 120, y_m = 120, rot_m = 0;
  int sin_t [16] = '{0, 1, 1, 2, 2, 2, 1, 1, 0, -1, -1, -2, -2, -2, -1, -1};
  tank_motion_ctrl dut (
    .clk(clk), .reset(reset), .switch_left(switch_left), .switch_right(switch_right),
    .switch_up(switch_up), .frame_start(frame_start), .heading(heading),
    .player_x(player_x), .player_y(player_y), .busy(busy), .update_done(update_done)
  );
  always #5 clk = ~clk;
  function automatic void model_reset();
    h_m = 0; x_m = 120; y_m = 120; rot_m = 0;
  endfunction
  function automatic void model_step(input bit l, input bit r, input bit u);
    if (l != r) begin
      rot_m++;
      if (rot_m == 4) begin
        rot_m = 0;
        h_m = (h_m + (r ? 1 : 15)) % 16;
      end
    end else rot_m = 0;
    if (u) begin
      x_m = (x_m + sin_t[h_m] + 256) % 256;
      y_m = (y_m - sin_t[(h_m + 4) % 16] + 240) % 240;
    end
  endfunction
  task automatic frame(input bit l, input bit r, input bit u);
    switch_left = l; switch_right = r; switch_up = u;
    repeat (3) @(posedge clk);
    #1 frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
    for (int c = 1; c <= 3; c++) begin
      cmp++;
      if (busy !== 1'b1 || update_done !== 1'b0 || heading !== 4'(h_m) || player_x !== 8'(x_m) || player_y !== 8'(y_m)) begin
        err++;
        $display("FAIL frame_hold c%0d: busy=%b done=%b h/x/y=%0d/%0d/%0d, want busy=1 done=0 %0d/%0d/%0d",
                 c, busy, update_done, heading, player_x, player_y, h_m, x_m, y_m);
      end
      @(posedge clk);
      #1;
    end
    model_step(l, r, u);
    cmp++;
    if (busy !== 1'b1 || update_done !== 1'b1 || heading !== 4'(h_m) || player_x !== 8'(x_m) || player_y !== 8'(y_m)) begin
      err++;
      $display("FAIL frame_commit: busy=%b done=%b h/x/y=%0d/%0d/%0d, want busy=1 done=1 %0d/%0d/%0d (keys l%0b r%0b u%0b)",
               busy, update_done, heading, player_x, player_y, h_m, x_m, y_m, l, r, u);
    end
    @(posedge clk);
    #1;
    cmp++;
    if (busy !== 1'b0 || update_done !== 1'b0) begin
      err++;
      $display("FAIL frame_idle: busy=%b done=%b, want 0 0", busy, update_done);
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    model_reset();
    cmp++;
    if (busy !== 1'b0 || update_done !== 1'b0 || heading !== 4'd0 || player_x !== 8'd120 || player_y !== 8'd120) begin
      err++;
      $display("FAIL reset_state: busy=%b done=%b h/x/y=%0d/%0d/%0d, want 0 0 0/120/120",
               busy, update_done, heading, player_x, player_y);
    end
  endtask
  task automatic test_idle_frame();
    frame(0, 0, 0);
    cmp++;
    if (heading !== 4'd0 || player_x !== 8'd120 || player_y !== 8'd120) begin
      err++;
      $display("FAIL idle_frame: h/x/y=%0d/%0d/%0d, want 0/120/120", heading, player_x, player_y);
    end
  endtask
  task automatic test_rotate();
    for (int f = 1; f <= 8; f++) begin
      frame(0, 1, 0);
      cmp++;
      if (heading !== 4'(f / 4)) begin
        err++;
        $display("FAIL rotate_f%0d: heading=%0d, want %0d", f, heading, f / 4);
      end
    end
  endtask
  task automatic test_wrap();
    for (int f = 0; f < 8; f++) frame(0, 1, 0);
    cmp++;
    if (heading !== 4'd4) begin
      err++;
      $display("FAIL heading_right: heading=%0d, want 4", heading);
    end
    for (int f = 0; f < 70; f++) frame(0, 0, 1);
    for (int f = 0; f < 16; f++) frame(0, 1, 0);
    for (int f = 0; f < 65; f++) frame(0, 0, 1);
    for (int f = 0; f < 32; f++) frame(1, 0, 0);
    cmp++;
    if (heading !== 4'd0) begin
      err++;
      $display("FAIL heading_up_again: heading=%0d, want 0", heading);
    end
    for (int f = 0; f < 65; f++) frame(0, 0, 1);
  endtask
  task automatic test_both_keys();
    logic [3:0] h0;
    frame(0, 1, 0);
    h0 = heading;
    for (int f = 0; f < 10; f++) frame(1, 1, 0);
    cmp++;
    if (heading !== h0) begin
      err++;
      $display("FAIL both_keys: heading=%0d, want %0d", heading, h0);
    end
    for (int f = 0; f < 4; f++) frame(0, 1, 0);
  endtask
  task automatic test_back_to_back();
    int n = 0;
    switch_left = 0; switch_right = 0; switch_up = 0;
    repeat (3) @(posedge clk);
    #1 frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
    @(posedge clk);
    #1 frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 frame_start = 0;
      if (update_done === 1'b1) begin
        n++;
        frame_start = 1;
      end
    end
    model_step(0, 0, 0);
    cmp++;
    if (n != 1 || busy !== 1'b0) begin
      err++;
      $display("FAIL back_to_back: done_pulses=%0d busy=%b, want 1 0", n, busy);
    end
    cmp++;
    if (heading !== 4'(h_m) || player_x !== 8'(x_m) || player_y !== 8'(y_m)) begin
      err++;
      $display("FAIL back_to_back_out: h/x/y=%0d/%0d/%0d, want %0d/%0d/%0d", heading, player_x, player_y, h_m, x_m, y_m);
    end
  endtask
  task automatic test_random();
    bit l, r, u;
    for (int f = 0; f < 120; f++) begin
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      u = ($urandom_range(0, 3) != 0);
      frame(l, r, u);
    end
  endtask
  task automatic test_reset_mid_update();
    int n = 0;
    switch_left = 0; switch_right = 1; switch_up = 1;
    repeat (3) @(posedge clk);
    #1 frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    cmp++;
    if (busy !== 1'b0 || update_done !== 1'b0 || heading !== 4'd0 || player_x !== 8'd120 || player_y !== 8'd120) begin
      err++;
      $display("FAIL reset_in_move: busy=%b done=%b h/x/y=%0d/%0d/%0d, want 0 0 0/120/120",
               busy, update_done, heading, player_x, player_y);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (update_done === 1'b1) n++;
    end
    cmp++;
    if (n != 0) begin
      err++;
      $display("FAIL reset_abort_done: done_pulses=%0d, want 0", n);
    end
  endtask
  task automatic test_reset_priority();
    reset = 1; frame_start = 1;
    @(posedge clk);
    #1 reset = 0; frame_start = 0;
    @(posedge clk);
    #1;
    cmp++;
    if (busy !== 1'b0 || update_done !== 1'b0) begin
      err++;
      $display("FAIL reset_priority: busy=%b done=%b, want 0 0", busy, update_done);
    end
    frame(0, 0, 1);
  endtask
  initial begin
    test_reset();
    test_idle_frame();
    test_rotate();
    test_wrap();
    test_both_keys();
    test_back_to_back();
    test_random();
    test_reset_mid_update();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
